// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage constants
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small pointer-based FIFO holding {pc, instr} entries with flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = wptr == rptr;
  assign dout = mem[rptr[AW-1:0]];
  // writing into a full FIFO is safe only when the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop) rptr <= rptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, instruction fetch into a FIFO, redirect and flush handling
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            misalign_err,
  output logic [31:0]     fetch_count
);
  logic [XLEN-1:0] pc;
  logic [2*XLEN-1:0] head;
  logic full, empty, pop, fetch_en, push;
  assign pop = out_valid & out_ready;
  assign fetch_en = !full | pop;
  // a redirect discards the word fetched in the same cycle
  assign push = fetch_en & !redirect_valid;
  assign imem_addr = pc;
  assign out_valid = !empty;
  assign out_pc = head[2*XLEN-1:XLEN];
  assign out_instr = empty ? XLEN'(INSTR_NOP) : head[XLEN-1:0];
  fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({pc, imem_instr}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      misalign_err <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc <= redirect_valid ? {redirect_target[XLEN-1:2], 2'b00} : fetch_en ? pc + XLEN'(PC_STEP) : pc;
      misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
      fetch_count <= fetch_count + 32'(push);
    end
  end
endmodule
